// File: rtl/rx_fifo_drain.sv
// rtl/rx_fifo_drain.sv - drains the RX FIFO into a 2-entry local buffer for AHB reads
//
// Ports:
//   rd_clk, rd_rst   AHB clock (HCLK) and synchronous active-high reset
//   enable           level; 1 allows fetching from the RX FIFO
//   flush            single-cycle pulse; discards local and FIFO-resident words
//   fifo_empty       RX FIFO empty flag
//   fifo_rd_en       RX FIFO read enable (data returns one cycle later)
//   fifo_rd_data     RX FIFO read data
//   rx_pop           AHB read strobe for the RX data register
//   rx_data          head word of the local buffer
//   rx_valid         rx_data holds a word
//   rx_level         local buffer occupancy, 0..2
//   rx_underflow     sticky; set by a pop with nothing to pop
//   clr_underflow    clears rx_underflow (a simultaneous set wins)
//   rx_word_cnt      wrapping count of accepted pops

module rx_fifo_drain (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        enable,
  input  logic        flush,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_rd_data,
  input  logic        rx_pop,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic [1:0]  rx_level,
  output logic        rx_underflow,
  input  logic        clr_underflow,
  output logic [15:0] rx_word_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state;
  logic        inflight;      // a read was issued last cycle; its data is on fifo_rd_data now
  logic [31:0] tail_word;     // second entry; the head entry is held directly in rx_data
  logic        pop_accepted;
  logic        ret_valid;     // returning word that must be written into the buffer
  logic        underflow_set;
  logic        flush_entry;
  logic [2:0]  projected;     // occupancy once the in-flight word lands and the pop leaves

  always_comb begin
    rx_valid      = (rx_level != 2'd0) && (state != ST_FLUSH);
    pop_accepted  = rx_pop && rx_valid;
    underflow_set = rx_pop && !rx_valid && (state != ST_FLUSH);
    flush_entry   = flush && (state != ST_FLUSH);
    // A word landing in the flush cycle itself is already part of the discarded set.
    ret_valid     = inflight && (state != ST_FLUSH) && !flush;
    projected     = {1'b0, rx_level} + {2'b00, inflight} - {2'b00, pop_accepted};
    fifo_rd_en    = 1'b0;
    case (state)
      ST_RUN:   fifo_rd_en = !fifo_empty && !flush && (projected < 3'd2);
      ST_FLUSH: fifo_rd_en = !fifo_empty;
      default:  fifo_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state        <= ST_IDLE;
      inflight     <= 1'b0;
      rx_level     <= 2'd0;
      rx_data      <= 32'h0000_0000;
      tail_word    <= 32'h0000_0000;
      rx_underflow <= 1'b0;
      rx_word_cnt  <= 16'h0000;
    end else begin
      inflight <= fifo_rd_en;

      if (underflow_set) begin
        rx_underflow <= 1'b1;
      end else if (clr_underflow) begin
        rx_underflow <= 1'b0;
      end

      if (pop_accepted) begin
        rx_word_cnt <= rx_word_cnt + 16'h0001;
      end

      case (state)
        ST_IDLE: begin
          if (flush) begin
            state <= ST_FLUSH;
          end else if (enable) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_FLUSH;
          end else if (!enable) begin
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          // Leave only once nothing is left in the FIFO and nothing is still returning.
          if (fifo_empty && !inflight) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (flush_entry) begin
        // Clearing the words too keeps flushed data from ever showing on rx_data.
        rx_level  <= 2'd0;
        rx_data   <= 32'h0000_0000;
        tail_word <= 32'h0000_0000;
      end else if (state != ST_FLUSH) begin
        case ({ret_valid, pop_accepted})
          2'b10: begin
            if (rx_level == 2'd0) begin
              rx_data  <= fifo_rd_data;
              rx_level <= 2'd1;
            end else if (rx_level == 2'd1) begin
              tail_word <= fifo_rd_data;
              rx_level  <= 2'd2;
            end
          end
          2'b01: begin
            if (rx_level == 2'd2) begin
              rx_data <= tail_word;
            end
            rx_level <= rx_level - 2'd1;
          end
          2'b11: begin
            // Head leaves and the new word joins the tail; occupancy is unchanged.
            if (rx_level == 2'd1) begin
              rx_data <= fifo_rd_data;
            end else begin
              rx_data   <= tail_word;
              tail_word <= fifo_rd_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_fifo_drain.sv
// tb/tb_rx_fifo_drain.sv - directed self-checking bench for rx_fifo_drain

module tb_rx_fifo_drain;

  logic        rd_clk;
  logic        rd_rst;
  logic        enable;
  logic        flush;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        rx_pop;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic [1:0]  rx_level;
  logic        rx_underflow;
  logic        clr_underflow;
  logic [15:0] rx_word_cnt;

  int tests_run = 0;
  int failures  = 0;

  // FIFO model: 64-entry array, or an endless source whose data is the read index.
  logic [31:0] mem [0:63];
  int          wr_ptr   = 0;
  int          rd_ptr   = 0;
  int          rd_count = 0;
  int          viol     = 0;
  logic        fifo_inf = 1'b0;

  rx_fifo_drain dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .enable        (enable),
    .flush         (flush),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .rx_pop        (rx_pop),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_level      (rx_level),
    .rx_underflow  (rx_underflow),
    .clr_underflow (clr_underflow),
    .rx_word_cnt   (rx_word_cnt)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = fifo_inf ? 1'b0 : (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fifo_inf ? rd_ptr : mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
      rd_count     <= rd_count + 1;
    end
  end

  always @(negedge rd_clk) begin
    if (fifo_rd_en && fifo_empty) viol = viol + 1;
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1; enable = 1'b0; flush = 1'b0; rx_pop = 1'b0; clr_underflow = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  task automatic test_reset();
    rd_rst = 1'b1; enable = 1'b0; flush = 1'b0; rx_pop = 1'b0; clr_underflow = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    tests_run++;
    if (rx_valid !== 1'b0 || rx_level !== 2'd0 || fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: valid=%b level=%0d rd_en=%b expected 0 0 0", rx_valid, rx_level, fifo_rd_en);
    end
    tests_run++;
    if (rx_data !== 32'h0 || rx_underflow !== 1'b0 || rx_word_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: data=%h uf=%b cnt=%h expected 0 0 0", rx_data, rx_underflow, rx_word_cnt);
    end
    rd_rst = 1'b0;
  endtask

  task automatic test_stream();
    int n = 0;
    int first = -1;
    int last = -1;
    int viol0;
    logic [31:0] exp_w;
    do_reset();
    for (int i = 1; i <= 8; i++) push(32'hA000_0000 + 32'(i));
    viol0 = viol;
    enable = 1'b1;
    for (int c = 1; c <= 40 && n < 8; c++) begin
      @(negedge rd_clk);
      if (rx_valid) begin
        exp_w = 32'hA000_0001 + 32'(n);
        tests_run++;
        if (rx_data !== exp_w) begin
          failures++;
          $display("FAIL stream_word%0d: got %h expected %h", n, rx_data, exp_w);
        end
        if (first < 0) first = c;
        last = c;
        rx_pop = 1'b1;
        n++;
      end else begin
        rx_pop = 1'b0;
      end
    end
    @(negedge rd_clk);
    rx_pop = 1'b0;
    tests_run++;
    if (n !== 8) begin
      failures++;
      $display("FAIL stream_timeout: popped %0d expected 8", n);
    end
    tests_run++;
    if (first !== 3 || last - first !== 7) begin
      failures++;
      $display("FAIL stream_rate: first=%0d span=%0d expected 3 and 7", first, last - first);
    end
    tests_run++;
    if (rx_word_cnt !== 16'd8 || rx_level !== 2'd0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: cnt=%0d level=%0d valid=%b expected 8 0 0", rx_word_cnt, rx_level, rx_valid);
    end
    tests_run++;
    if (viol !== viol0) begin
      failures++;
      $display("FAIL stream_rd_empty: %0d reads while empty expected 0", viol - viol0);
    end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    int rc0;
    do_reset();
    for (int i = 1; i <= 3; i++) push(32'hB000_0000 + 32'(i));
    rc0 = rd_count;
    enable = 1'b1;
    repeat (8) @(negedge rd_clk);
    tests_run++;
    if (rx_level !== 2'd2 || rx_data !== 32'hB000_0001 || fifo_rd_en !== 1'b0 || rd_count - rc0 !== 2) begin
      failures++;
      $display("FAIL bp_full: level=%0d data=%h rd_en=%b reads=%0d expected 2 b0000001 0 2",
               rx_level, rx_data, fifo_rd_en, rd_count - rc0);
    end
    rx_pop = 1'b1;
    @(negedge rd_clk);
    rx_pop = 1'b0;
    tests_run++;
    if (rx_data !== 32'hB000_0002 || rx_level !== 2'd1 || rx_word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL bp_pop: data=%h level=%0d cnt=%0d expected b0000002 1 1", rx_data, rx_level, rx_word_cnt);
    end
    repeat (2) @(negedge rd_clk);
    tests_run++;
    if (rx_level !== 2'd2 || rd_count - rc0 !== 3 || fifo_rd_en !== 1'b0 || rx_data !== 32'hB000_0002) begin
      failures++;
      $display("FAIL bp_refill: level=%0d reads=%0d rd_en=%b data=%h expected 2 3 0 b0000002",
               rx_level, rd_count - rc0, fifo_rd_en, rx_data);
    end
    enable = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    rx_pop = 1'b1;
    @(negedge rd_clk);
    rx_pop = 1'b0;
    tests_run++;
    if (rx_underflow !== 1'b1 || rx_word_cnt !== 16'd0 || rx_level !== 2'd0) begin
      failures++;
      $display("FAIL uf_set: uf=%b cnt=%0d level=%0d expected 1 0 0", rx_underflow, rx_word_cnt, rx_level);
    end
    rx_pop = 1'b1;
    clr_underflow = 1'b1;
    @(negedge rd_clk);
    rx_pop = 1'b0;
    tests_run++;
    if (rx_underflow !== 1'b1) begin
      failures++;
      $display("FAIL uf_set_wins: uf=%b expected 1", rx_underflow);
    end
    @(negedge rd_clk);
    clr_underflow = 1'b0;
    tests_run++;
    if (rx_underflow !== 1'b0) begin
      failures++;
      $display("FAIL uf_clear: uf=%b expected 0", rx_underflow);
    end
  endtask

  task automatic test_flush();
    int rc0;
    int leaked = 0;
    int seen_valid = 0;
    int got = 0;
    do_reset();
    for (int i = 1; i <= 5; i++) push(32'hC000_0000 + 32'(i));
    rc0 = rd_count;
    enable = 1'b1;
    repeat (3) @(negedge rd_clk);
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 32'hC000_0001 || rx_level !== 2'd1 || rd_count - rc0 !== 2) begin
      failures++;
      $display("FAIL fl_pre: valid=%b data=%h level=%0d reads=%0d expected 1 c0000001 1 2",
               rx_valid, rx_data, rx_level, rd_count - rc0);
    end
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b1;
    rx_pop = 1'b1;
    tests_run++;
    if (rx_valid !== 1'b0 || rx_level !== 2'd0) begin
      failures++;
      $display("FAIL fl_entry: valid=%b level=%0d expected 0 0", rx_valid, rx_level);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge rd_clk);
      flush = 1'b0;
      rx_pop = 1'b0;
      if (rx_valid) seen_valid++;
      for (int k = 2; k <= 5; k++) if (rx_data === 32'hC000_0000 + 32'(k)) leaked++;
    end
    tests_run++;
    if (rx_underflow !== 1'b0 || rx_word_cnt !== 16'd0) begin
      failures++;
      $display("FAIL fl_pop_ignored: uf=%b cnt=%0d expected 0 0", rx_underflow, rx_word_cnt);
    end
    tests_run++;
    if (leaked !== 0 || seen_valid !== 0) begin
      failures++;
      $display("FAIL fl_leak: leaked=%0d valid_cycles=%0d expected 0 0", leaked, seen_valid);
    end
    tests_run++;
    if (fifo_empty !== 1'b1 || rd_count - rc0 !== 5) begin
      failures++;
      $display("FAIL fl_drain: empty=%b reads=%0d expected 1 5", fifo_empty, rd_count - rc0);
    end
    push(32'hD000_0001);
    for (int c = 0; c < 10 && !rx_valid; c++) @(negedge rd_clk);
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 32'hD000_0001) begin
      failures++;
      $display("FAIL fl_resume: valid=%b data=%h expected 1 d0000001", rx_valid, rx_data);
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    fifo_inf = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 70000 && n < 65535; c++) begin
      @(negedge rd_clk);
      rx_pop = rx_valid;
      if (rx_valid) n++;
    end
    @(negedge rd_clk);
    rx_pop = 1'b0;
    tests_run++;
    if (rx_word_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preload: cnt=%h expected ffff", rx_word_cnt);
    end
    @(negedge rd_clk);
    rx_pop = 1'b1;
    @(negedge rd_clk);
    rx_pop = 1'b0;
    tests_run++;
    if (rx_word_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_rollover: cnt=%h expected 0000", rx_word_cnt);
    end
    enable = 1'b0;
    repeat (3) @(negedge rd_clk);
    fifo_inf = 1'b0;
    wr_ptr = rd_ptr;
  endtask

  task automatic test_midstream_reset();
    int found = 0;
    int seen_valid = 0;
    do_reset();
    rx_pop = 1'b1;
    @(negedge rd_clk);
    rx_pop = 1'b0;
    tests_run++;
    if (rx_underflow !== 1'b1) begin
      failures++;
      $display("FAIL mr_pre_uf: uf=%b expected 1", rx_underflow);
    end
    for (int i = 1; i <= 8; i++) push(32'hE000_0000 + 32'(i));
    enable = 1'b1;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      @(negedge rd_clk);
      rx_pop = rx_valid;
      if (c >= 5 && fifo_rd_en) found = 1;
    end
    tests_run++;
    if (found !== 1) begin
      failures++;
      $display("FAIL mr_no_read: found=%0d expected 1", found);
    end
    rd_rst = 1'b1;
    rx_pop = 1'b0;
    @(negedge rd_clk);
    tests_run++;
    if (rx_valid !== 1'b0 || rx_level !== 2'd0 || rx_data !== 32'h0 || rx_underflow !== 1'b0 ||
        rx_word_cnt !== 16'h0 || fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL mr_state: valid=%b level=%0d data=%h uf=%b cnt=%0d rd_en=%b expected all 0",
               rx_valid, rx_level, rx_data, rx_underflow, rx_word_cnt, fifo_rd_en);
    end
    rd_rst = 1'b0;
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge rd_clk);
      if (rx_valid || rx_level != 2'd0) seen_valid++;
    end
    tests_run++;
    if (seen_valid !== 0) begin
      failures++;
      $display("FAIL mr_discard: %0d cycles with a captured word expected 0", seen_valid);
    end
  endtask

  initial begin
    rd_rst = 1'b1; enable = 1'b0; flush = 1'b0; rx_pop = 1'b0; clr_underflow = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_underflow();
    test_flush();
    test_wrap();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
